// File: rtl/parking_lot_controller.sv
// ---------------------------------------------------------------------------
// parking_lot_controller
//
// Occupancy core of the car park. Keeps one occupancy bit per spot, hands
// the lowest eligible free spot to an arriving car through a req/ack
// handshake, holds the entry barrier open for a fixed number of cycles and
// frees spots by explicit spot ID on exit. The top RESERVED spots are
// permit-only.
//
// Parameters
//   NUM_SPOTS    number of spots (>= 2)
//   RESERVED     permit-only spots at the top indices (< NUM_SPOTS)
//   GATE_CYCLES  cycles the barrier stays open after an accept (>= 1)
//
// Ports
//   clk              clock, all state changes on the rising edge
//   reset_n          asynchronous active-low reset
//   enter_req        car waiting at entry, held until ack or reject
//   enter_permit     car holds a permit, sampled with enter_req
//   enter_ack        one-cycle pulse, spot granted
//   enter_spot       granted spot index, held until the next grant
//   enter_reject     one-cycle pulse, no eligible spot free
//   gate_open        entry barrier drive
//   leave_req        single-cycle exit event
//   leave_spot       spot being vacated, qualified by leave_req
//   leave_ack        one-cycle pulse, spot freed
//   leave_err        one-cycle pulse, exit named a bad or already-free spot
//   occupancy        bit i set means spot i is taken
//   available_slots  registered count of free spots (reserved included)
//   parking_full     registered, all spots taken
//
// Every output comes straight from a flop; no input reaches an output
// without passing through a register.
// ---------------------------------------------------------------------------
module parking_lot_controller #(
    parameter int  NUM_SPOTS   = 8,
    parameter int  RESERVED    = 0,
    parameter int  GATE_CYCLES = 4,
    localparam int ID_W        = (NUM_SPOTS > 2) ? $clog2(NUM_SPOTS) : 1,
    localparam int CNT_W       = $clog2(NUM_SPOTS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enter_req,
    input  logic                 enter_permit,
    output logic                 enter_ack,
    output logic [ID_W-1:0]      enter_spot,
    output logic                 enter_reject,
    output logic                 gate_open,
    input  logic                 leave_req,
    input  logic [ID_W-1:0]      leave_spot,
    output logic                 leave_ack,
    output logic                 leave_err,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [CNT_W-1:0]     available_slots,
    output logic                 parking_full
);

    localparam int GC_W       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int OPEN_SPOTS = NUM_SPOTS - RESERVED;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               r_state;
    logic [GC_W-1:0]      r_gate_cnt;
    logic [NUM_SPOTS-1:0] r_occ;
    logic                 r_enter_ack;
    logic [ID_W-1:0]      r_enter_spot;
    logic                 r_enter_reject;
    logic                 r_gate_open;
    logic                 r_leave_ack;
    logic                 r_leave_err;
    logic [CNT_W-1:0]     r_avail;
    logic                 r_full;

    // -----------------------------------------------------------------------
    // Combinational next values
    // -----------------------------------------------------------------------
    state_t               w_next_state;
    logic [GC_W-1:0]      w_gate_cnt_next;
    logic [NUM_SPOTS-1:0] w_elig_mask;
    logic [NUM_SPOTS-1:0] w_free_elig;
    logic [NUM_SPOTS-1:0] w_grant_onehot;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_reject;
    logic [NUM_SPOTS-1:0] w_leave_onehot;
    logic                 w_leave_ok;
    logic                 w_leave_bad;
    logic [NUM_SPOTS-1:0] w_occ_next;
    logic [CNT_W-1:0]     w_free_cnt;

    // -----------------------------------------------------------------------
    // Allocation: eligible set and lowest-index free eligible spot. Uses the
    // occupancy before any exit in the same cycle, so a spot freed this
    // cycle is never granted this cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        w_elig_mask    = '0;
        w_grant_onehot = '0;
        w_grant_idx    = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (enter_permit || (i < OPEN_SPOTS)) begin
                w_elig_mask[i] = 1'b1;
            end
        end
        w_free_elig = w_elig_mask & ~r_occ;
        w_found     = |w_free_elig;
        // Scan downwards so the last hit, the lowest index, wins.
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (w_free_elig[i]) begin
                w_grant_onehot    = '0;
                w_grant_onehot[i] = 1'b1;
                w_grant_idx       = ID_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Entry state machine, next-state logic. The gate counter is loaded with
    // GATE_CYCLES-1 on accept and the machine leaves GATE on the edge where
    // it has counted down to zero, giving exactly GATE_CYCLES open cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_gate_cnt_next = r_gate_cnt;
        w_accept        = 1'b0;
        w_reject        = 1'b0;
        case (r_state)
            IDLE: begin
                if (enter_req) begin
                    if (w_found) begin
                        w_accept        = 1'b1;
                        w_next_state    = GATE;
                        w_gate_cnt_next = GC_W'(GATE_CYCLES - 1);
                    end else begin
                        w_reject     = 1'b1;
                        w_next_state = WAIT_REL;
                    end
                end
            end
            GATE: begin
                if (r_gate_cnt == '0) begin
                    w_next_state = IDLE;
                end else begin
                    w_gate_cnt_next = r_gate_cnt - GC_W'(1);
                end
            end
            WAIT_REL: begin
                // A rejected car must drop its request before the next one
                // can be served.
                if (!enter_req) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Exit path. The one-hot decode stays empty for an index beyond the last
    // spot, which then falls into the error case.
    // -----------------------------------------------------------------------
    always_comb begin
        w_leave_onehot = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (leave_spot == ID_W'(i)) begin
                w_leave_onehot[i] = 1'b1;
            end
        end
        w_leave_ok  = leave_req && (|(r_occ & w_leave_onehot));
        w_leave_bad = leave_req && !w_leave_ok;
    end

    // -----------------------------------------------------------------------
    // Occupancy update and free-slot count of the new occupancy, so the
    // registered count moves on the same edge as the occupancy bits. A grant
    // always targets a free spot and an exit an occupied one, so the set and
    // clear masks never overlap.
    // -----------------------------------------------------------------------
    always_comb begin
        w_occ_next = r_occ;
        if (w_leave_ok) begin
            w_occ_next = w_occ_next & ~w_leave_onehot;
        end
        if (w_accept) begin
            w_occ_next = w_occ_next | w_grant_onehot;
        end
        w_free_cnt = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            if (!w_occ_next[i]) begin
                w_free_cnt = w_free_cnt + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Entry state machine, state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, whatever the statement order.
            r_state    <= w_next_state;
            r_gate_cnt <= w_gate_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output and occupancy registers. The asynchronous reset drops the
    // barrier immediately, even in the middle of GATE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the occupancy vector is a handful of flops, not a RAM,
            // so it is cleared by reset together with everything else.
            r_occ          <= '0;
            r_enter_ack    <= 1'b0;
            r_enter_spot   <= '0;
            r_enter_reject <= 1'b0;
            r_gate_open    <= 1'b0;
            r_leave_ack    <= 1'b0;
            r_leave_err    <= 1'b0;
            r_avail        <= CNT_W'(NUM_SPOTS);
            r_full         <= 1'b0;
        end else begin
            r_occ          <= w_occ_next;
            r_enter_ack    <= w_accept;
            r_enter_reject <= w_reject;
            r_gate_open    <= (w_next_state == GATE);
            r_leave_ack    <= w_leave_ok;
            r_leave_err    <= w_leave_bad;
            r_avail        <= w_free_cnt;
            r_full         <= (w_free_cnt == '0);
            if (w_accept) begin
                r_enter_spot <= w_grant_idx;
            end
        end
    end

    assign enter_ack       = r_enter_ack;
    assign enter_spot      = r_enter_spot;
    assign enter_reject    = r_enter_reject;
    assign gate_open       = r_gate_open;
    assign leave_ack       = r_leave_ack;
    assign leave_err       = r_leave_err;
    assign occupancy       = r_occ;
    assign available_slots = r_avail;
    assign parking_full    = r_full;

endmodule

// File: tb/tb_parking_lot_controller.sv
// ---------------------------------------------------------------------------
// tb_parking_lot_controller
//
// Directed bench for parking_lot_controller with NUM_SPOTS=4, RESERVED=1,
// GATE_CYCLES=3. Expected entry and exit responses are queued when the
// stimulus is driven and compared by a monitor when the DUT pulses them;
// state such as occupancy and barrier timing is compared inline.
// ---------------------------------------------------------------------------
module tb_parking_lot_controller;

    localparam int NUM_SPOTS   = 4;
    localparam int RESERVED    = 1;
    localparam int GATE_CYCLES = 3;
    localparam int ID_W        = 2;
    localparam int CNT_W       = 3;

    typedef struct {
        logic            is_ack;
        logic [ID_W-1:0] spot;
    } enter_exp_t;

    logic                 clk;
    logic                 reset_n;
    logic                 enter_req;
    logic                 enter_permit;
    logic                 enter_ack;
    logic [ID_W-1:0]      enter_spot;
    logic                 enter_reject;
    logic                 gate_open;
    logic                 leave_req;
    logic [ID_W-1:0]      leave_spot;
    logic                 leave_ack;
    logic                 leave_err;
    logic [NUM_SPOTS-1:0] occupancy;
    logic [CNT_W-1:0]     available_slots;
    logic                 parking_full;

    int checks = 0;
    int errors = 0;

    enter_exp_t q_enter[$];
    logic       q_leave[$];

    parking_lot_controller #(
        .NUM_SPOTS  (NUM_SPOTS),
        .RESERVED   (RESERVED),
        .GATE_CYCLES(GATE_CYCLES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enter_req      (enter_req),
        .enter_permit   (enter_permit),
        .enter_ack      (enter_ack),
        .enter_spot     (enter_spot),
        .enter_reject   (enter_reject),
        .gate_open      (gate_open),
        .leave_req      (leave_req),
        .leave_spot     (leave_spot),
        .leave_ack      (leave_ack),
        .leave_err      (leave_err),
        .occupancy      (occupancy),
        .available_slots(available_slots),
        .parking_full   (parking_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares DUT response pulses against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (enter_ack || enter_reject) begin
                check("enter_expected", 32'(q_enter.size() != 0), 1);
                if (q_enter.size() != 0) begin
                    enter_exp_t e;
                    e = q_enter.pop_front();
                    check("enter_ack", 32'(enter_ack), 32'(e.is_ack));
                    check("enter_reject", 32'(enter_reject), 32'(!e.is_ack));
                    if (e.is_ack) begin
                        check("enter_spot", 32'(enter_spot), 32'(e.spot));
                    end
                end
            end
            if (leave_ack || leave_err) begin
                check("leave_expected", 32'(q_leave.size() != 0), 1);
                if (q_leave.size() != 0) begin
                    logic l;
                    l = q_leave.pop_front();
                    check("leave_ack", 32'(leave_ack), 32'(l));
                    check("leave_err", 32'(leave_err), 32'(!l));
                end
            end
        end
    end

    // One car at the entry: request, wait for the response, drop the
    // request, and for an accept measure how long the barrier stays open.
    task automatic do_entry(input logic permit, input logic is_ack, input logic [ID_W-1:0] spot);
        int n;
        int g;
        enter_exp_t e;
        e.is_ack = is_ack;
        e.spot   = spot;
        q_enter.push_back(e);
        enter_req    = 1'b1;
        enter_permit = permit;
        n = 0;
        do begin
            step();
            n++;
        end while (!(enter_ack || enter_reject) && n < 10);
        check("enter_latency", 32'(n), 1);
        enter_req    = 1'b0;
        enter_permit = 1'b0;
        if (is_ack) begin
            g = 0;
            while (gate_open && g < 20) begin
                g++;
                step();
            end
            check("gate_cycles", 32'(g), GATE_CYCLES);
            check("spot_hold", 32'(enter_spot), 32'(spot));
        end else begin
            step();
        end
    endtask

    task automatic do_leave(input logic [ID_W-1:0] spot, input logic is_ack);
        q_leave.push_back(is_ack);
        leave_req  = 1'b1;
        leave_spot = spot;
        step();
        leave_req  = 1'b0;
        leave_spot = '0;
    endtask

    initial begin
        reset_n      = 1'b0;
        enter_req    = 1'b0;
        enter_permit = 1'b0;
        leave_req    = 1'b0;
        leave_spot   = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        check("rst_occupancy", 32'(occupancy), 'h0);
        check("rst_available", 32'(available_slots), 4);
        check("rst_full", 32'(parking_full), 0);
        check("rst_gate", 32'(gate_open), 0);
        check("rst_ack", 32'(enter_ack), 0);

        // Allocation order and barrier timing for non-permit cars
        do_entry(1'b0, 1'b1, 2'd0);
        do_entry(1'b0, 1'b1, 2'd1);
        do_entry(1'b0, 1'b1, 2'd2);
        check("alloc_occupancy", 32'(occupancy), 'h7);
        check("alloc_available", 32'(available_slots), 1);
        check("alloc_full", 32'(parking_full), 0);

        // Reserved spot: refused without a permit, granted with one
        do_entry(1'b0, 1'b0, 2'd0);
        check("rej_occupancy", 32'(occupancy), 'h7);
        check("rej_available", 32'(available_slots), 1);
        do_entry(1'b1, 1'b1, 2'd3);
        check("full_occupancy", 32'(occupancy), 'hF);
        check("full_available", 32'(available_slots), 0);
        check("full_flag", 32'(parking_full), 1);

        // Simultaneous exit and entry while full: the freed spot is not
        // visible to the allocation in the same cycle.
        q_enter.push_back('{1'b0, 2'd0});
        q_leave.push_back(1'b1);
        enter_req    = 1'b1;
        enter_permit = 1'b1;
        leave_req    = 1'b1;
        leave_spot   = 2'd1;
        step();
        leave_req = 1'b0;
        check("simul_reject", 32'(enter_reject), 1);
        check("simul_leave_ack", 32'(leave_ack), 1);
        check("simul_occupancy", 32'(occupancy), 'hD);
        check("simul_available", 32'(available_slots), 1);
        check("simul_full", 32'(parking_full), 0);
        enter_req    = 1'b0;
        enter_permit = 1'b0;
        step();
        check("leave_ack_pulse", 32'(leave_ack), 0);
        check("reject_pulse", 32'(enter_reject), 0);
        do_entry(1'b1, 1'b1, 2'd1);
        check("refill_occupancy", 32'(occupancy), 'hF);

        // Exits: valid, repeated (already free), valid on the reserved spot
        do_leave(2'd2, 1'b1);
        check("leave2_occupancy", 32'(occupancy), 'hB);
        check("leave2_available", 32'(available_slots), 1);
        do_leave(2'd2, 1'b0);
        check("err_occupancy", 32'(occupancy), 'hB);
        check("err_available", 32'(available_slots), 1);
        check("err_pulse_level", 32'(leave_err), 1);
        step();
        check("err_pulse_end", 32'(leave_err), 0);
        do_leave(2'd3, 1'b1);
        check("leave3_occupancy", 32'(occupancy), 'h3);
        check("leave3_available", 32'(available_slots), 2);
        step();

        // Reset in the second GATE cycle
        q_enter.push_back('{1'b1, 2'd2});
        enter_req = 1'b1;
        step();
        enter_req = 1'b0;
        check("mid_gate_open", 32'(gate_open), 1);
        check("mid_occupancy", 32'(occupancy), 'h7);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_gate_drop", 32'(gate_open), 0);
        check("async_occupancy", 32'(occupancy), 'h0);
        check("async_available", 32'(available_slots), 4);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        do_entry(1'b0, 1'b1, 2'd0);
        check("post_rst_occupancy", 32'(occupancy), 'h1);
        step();

        check("enter_queue_drained", 32'(q_enter.size()), 0);
        check("leave_queue_drained", 32'(q_leave.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
